ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_pkg.sv | 23 ++
 rtl/ifetch_fifo.sv | 60 ++++++
 rtl/ifetch_unit.sv | 123 ++++++++++++
 tb/tb_ifetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, buffer entry
// layout and address constants.
package ifetch_unit_pkg;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & ~32'(INSTR_BYTES - 1);
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// In-order instruction buffer with single-cycle flush; the head entry reads as
// zero whenever the buffer is empty.
module ifetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             almost_full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
      $error("ifetch_fifo: DEPTH must be 2 or 4");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // NOTE: the storage array is not reset; the empty flag masks stale contents,
   // which keeps reset fan-out off the data path.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign full_o        = (count_q == CW'(DEPTH));
   assign almost_full_o = (count_q == CW'(DEPTH - 1));
   assign empty_o       = (count_q == '0);
   assign count_o       = count_q;
   assign rdata_o       = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding an in-order
// instruction buffer, with redirect flush and discard of in-flight data.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_e  state_q;
   logic [31:0]   fetch_pc_q, addr_q, next_pc, redir_pc;
   logic          req_q, push, pop, slot_free;
   logic          fifo_full, fifo_afull, fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  push_entry, head_entry;

   assign redir_pc   = align_pc(redirect_pc);
   assign next_pc    = fetch_pc_q + 32'(INSTR_BYTES);
   assign pop        = inst_valid && inst_ready;
   assign push       = (state_q == ST_WAIT) && imem_ack && !redirect_valid;
   assign push_entry = '{pc: fetch_pc_q, data: imem_rdata};

   // Is there room for one more entry after this cycle's push/pop settle?
   // NOTE: always_comb assigns a default first so no path can infer a latch.
   always_comb begin
      slot_free = 1'b0;
      if (pop)       slot_free = !(push && fifo_full);
      else if (push) slot_free = !fifo_afull && !fifo_full;
      else           slot_free = !fifo_full;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (redirect_valid) begin
                  fetch_pc_q <= redir_pc;
               end else if (slot_free) begin
                  state_q <= ST_WAIT;
                  req_q   <= 1'b1;
                  addr_q  <= fetch_pc_q;
               end
            end
            ST_WAIT: begin
               if (imem_ack && redirect_valid) begin
                  fetch_pc_q <= redir_pc;
                  addr_q     <= redir_pc;
               end else if (imem_ack) begin
                  fetch_pc_q <= next_pc;
                  if (slot_free) begin
                     addr_q <= next_pc;
                  end else begin
                     state_q <= ST_IDLE;
                     req_q   <= 1'b0;
                  end
               end else if (redirect_valid) begin
                  fetch_pc_q <= redir_pc;
                  state_q    <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               // The buffer was flushed on entry, so the new request always has a slot.
               if (redirect_valid) fetch_pc_q <= redir_pc;
               if (imem_ack) begin
                  state_q <= ST_WAIT;
                  addr_q  <= redirect_valid ? redir_pc : fetch_pc_q;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   ifetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .push_i        (push),
      .pop_i         (pop),
      .flush_i       (redirect_valid),
      .wdata_i       (push_entry),
      .rdata_o       (head_entry),
      .full_o        (fifo_full),
      .almost_full_o (fifo_afull),
      .empty_o       (fifo_empty),
      .count_o       (fifo_count)
   );

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = !fifo_empty;
   assign inst_data  = head_entry.data;
   assign inst_pc    = head_entry.pc;

   assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CW'(BUF_DEPTH));
   assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a parameterised-latency memory, an in-order fetch
// stream model with bus-protocol checks, and directed scenarios.
module tb_ifetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   int n_checks = 0;
   int n_errors = 0;

   ifetch_unit #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory: acks once the request has waited `lat` cycles (0 = same cycle).
   int lat = 0;
   int wcnt;
   int ack_cnt = 0;
   assign imem_ack   = imem_req && (wcnt == lat);
   assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      wcnt <= 0;
      else if (imem_req && !imem_ack)  wcnt <= wcnt + 1;
      else                             wcnt <= 0;
   end

   always @(posedge clk) begin
      if (imem_ack) ack_cnt <= ack_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stream model: decode must see consecutive word addresses starting at the
   // reset PC or the latest redirect target, with the memory word for each.
   logic [31:0] exp_pc;
   bit          expect_empty;
   bit          prev_req, prev_ack;
   logic [31:0] prev_addr;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_pc       = RESET_PC;
         expect_empty = 1'b0;
         prev_req     = 1'b0;
         prev_ack     = 1'b0;
         check("rst_req",   imem_req,   0);
         check("rst_valid", inst_valid, 0);
         check("rst_addr",  imem_addr,  0);
         check("rst_data",  inst_data,  0);
         check("rst_pc",    inst_pc,    0);
      end else begin
         if (expect_empty) check("valid_after_redirect", inst_valid, 0);
         if (prev_req && !prev_ack) begin
            check("req_held",  imem_req,  1);
            check("addr_held", imem_addr, prev_addr);
         end
         if (imem_req) check("addr_aligned", imem_addr[1:0], 0);
         if (redirect_valid) begin
            exp_pc       = {redirect_pc[31:2], 2'b00};
            expect_empty = 1'b1;
         end else begin
            expect_empty = 1'b0;
            if (inst_valid && inst_ready) begin
               check("stream_pc",   inst_pc,   exp_pc);
               check("stream_data", inst_data, mem_word(exp_pc));
               exp_pc = exp_pc + 32'd4;
            end
         end
         prev_req  = imem_req;
         prev_ack  = imem_ack;
         prev_addr = imem_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [31:0] t1_pcs  [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
   logic [31:0] t1_data [4] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};
   int          acks0;

   initial begin
      rst_n          = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Zero-latency memory, decode always ready: back-to-back stream.
      lat = 0; inst_ready = 1'b1;
      do_reset();
      check("t1_req_pre_edge", imem_req, 0);
      tick();
      check("t1_first_req",  imem_req,  1);
      check("t1_first_addr", imem_addr, RESET_PC);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t1_valid", inst_valid, 1);
         check("t1_pc",    inst_pc,    t1_pcs[i]);
         check("t1_data",  inst_data,  t1_data[i]);
         tick();
      end

      // Decode stalled: exactly two entries fetched, then no further requests.
      lat = 0; inst_ready = 1'b0;
      do_reset();
      acks0 = ack_cnt;
      repeat (10) tick();
      check("t2_acks",  ack_cnt - acks0, 2);
      check("t2_req",   imem_req,   0);
      check("t2_valid", inst_valid, 1);
      check("t2_pc0",   inst_pc,    32'h0);
      inst_ready = 1'b1;
      tick();
      check("t2_pc4", inst_pc, 32'h4);
      tick();
      check("t2_valid8", inst_valid, 1);
      check("t2_pc8",    inst_pc,    32'h8);

      // 3-cycle latency, redirect while waiting and again while flushing.
      lat = 3; inst_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      tick();
      redirect_pc = 32'h40;
      tick();
      redirect_valid = 1'b0; redirect_pc = '0;
      check("t3_old_req",  imem_req,  1);
      check("t3_old_addr", imem_addr, 32'h0);
      check("t3_old_ack",  imem_ack,  1);
      tick();
      check("t3_new_req",  imem_req,  1);
      check("t3_new_addr", imem_addr, 32'h40);
      for (int i = 0; i < 20 && !inst_valid; i++) tick();
      check("t3_valid", inst_valid, 1);
      check("t3_pc",    inst_pc,    32'h40);
      check("t3_data",  inst_data,  32'hC0DE_0040);

      // Redirect coincident with the ack for address 8.
      lat = 0; inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h8); i++) tick();
      check("t4_at_8", imem_addr, 32'h8);
      check("t4_ack",  imem_ack,  1);
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect_valid = 1'b0; redirect_pc = '0;
      check("t4_req",   imem_req,   1);
      check("t4_addr",  imem_addr,  32'h100);
      check("t4_empty", inst_valid, 0);
      tick();
      check("t4_valid", inst_valid, 1);
      check("t4_pc",    inst_pc,    32'h100);
      check("t4_data",  inst_data,  32'hC0DE_0100);

      // Address wrap from the top of the address space.
      lat = 0; inst_ready = 1'b1;
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0; redirect_pc = '0;
      check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("t5_pc_top",   inst_pc,   32'hFFFF_FFFC);
      check("t5_data_top", inst_data, 32'h3F21_FFFC);
      check("t5_addr_wrap", imem_addr, 32'h0);
      tick();
      check("t5_pc_wrap",   inst_pc,   32'h0);
      check("t5_data_wrap", inst_data, 32'hC0DE_0000);

      // Asynchronous reset mid-request with buffered data.
      lat = 2; inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && !(inst_valid && imem_req); i++) tick();
      check("t6_setup", inst_valid && imem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_req_drop",   imem_req,   0);
      check("t6_valid_drop", inst_valid, 0);
      check("t6_addr_zero",  imem_addr,  0);
      check("t6_pc_zero",    inst_pc,    0);
      tick();
      tick();
      rst_n = 1'b1;
      check("t6_req_pre_edge", imem_req, 0);
      tick();
      check("t6_first_req",  imem_req,  1);
      check("t6_first_addr", imem_addr, RESET_PC);
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
